// File: rtl/param_universal_shift_reg.sv
// Parametrised universal shift register: multi-position shift, rotate, arithmetic shift,
// parallel load and clear, with clock enable, last-shifted-out bit and zero flag.
module param_universal_shift_reg #(
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [AW-1:0]    amt,
    input  logic             MSB_in,
    input  logic             LSB_in,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic             shift_out,
    output logic             zero
);

    localparam logic [2:0] MODE_HOLD  = 3'b000;
    localparam logic [2:0] MODE_SRL   = 3'b001;
    localparam logic [2:0] MODE_SLL   = 3'b010;
    localparam logic [2:0] MODE_LOAD  = 3'b011;
    localparam logic [2:0] MODE_ROR   = 3'b100;
    localparam logic [2:0] MODE_ROL   = 3'b101;
    localparam logic [2:0] MODE_ASR   = 3'b110;
    localparam logic [2:0] MODE_CLEAR = 3'b111;

    logic [WIDTH-1:0] srl_res;
    logic [WIDTH-1:0] sll_res;
    logic [WIDTH-1:0] ror_res;
    logic [WIDTH-1:0] rol_res;
    logic [WIDTH-1:0] asr_res;
    logic [AW-1:0]    right_idx;
    logic [AW-1:0]    left_idx;
    logic             so_right;
    logic             so_left;
    logic             shift_mode;
    logic [WIDTH-1:0] next_out;
    logic             next_so;

    // Each result is formed in a double-width window so the fill bits slide in naturally.
    assign srl_res = WIDTH'({{WIDTH{MSB_in}}, out} >> amt);
    assign asr_res = WIDTH'({{WIDTH{out[WIDTH-1]}}, out} >> amt);
    assign ror_res = WIDTH'({out, out} >> amt);
    assign sll_res = WIDTH'(({out, {WIDTH{LSB_in}}} << amt) >> WIDTH);
    assign rol_res = WIDTH'(({out, out} << amt) >> WIDTH);

    // WIDTH is a power of two, so W-k wraps exactly within AW bits.
    assign right_idx = amt - 1'b1;
    assign left_idx  = {AW{1'b0}} - amt;
    assign so_right  = out[right_idx];
    assign so_left   = out[left_idx];

    assign shift_mode = (mode != MODE_HOLD) && (mode != MODE_LOAD) && (mode != MODE_CLEAR);

    // Next-state selection; a zero distance in any shift/rotate mode acts as hold.
    always_comb begin
        next_out = out;
        next_so  = shift_out;
        if (shift_mode && (amt == {AW{1'b0}})) begin
            next_out = out;
            next_so  = shift_out;
        end else begin
            case (mode)
                MODE_HOLD: begin
                    next_out = out;
                    next_so  = shift_out;
                end
                MODE_SRL: begin
                    next_out = srl_res;
                    next_so  = so_right;
                end
                MODE_SLL: begin
                    next_out = sll_res;
                    next_so  = so_left;
                end
                MODE_LOAD: begin
                    next_out = in;
                    next_so  = shift_out;
                end
                MODE_ROR: begin
                    next_out = ror_res;
                    next_so  = so_right;
                end
                MODE_ROL: begin
                    next_out = rol_res;
                    next_so  = so_left;
                end
                MODE_ASR: begin
                    next_out = asr_res;
                    next_so  = so_right;
                end
                MODE_CLEAR: begin
                    next_out = {WIDTH{1'b0}};
                    next_so  = 1'b0;
                end
                default: begin
                    next_out = {WIDTH{1'b0}};
                    next_so  = 1'b0;
                end
            endcase
        end
    end

    // State register with asynchronous clear and clock enable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out       <= {WIDTH{1'b0}};
            shift_out <= 1'b0;
        end else if (en) begin
            out       <= next_out;
            shift_out <= next_so;
        end else begin
            out       <= out;
            shift_out <= shift_out;
        end
    end

    assign zero = (out == {WIDTH{1'b0}});

endmodule

// File: tb/tb_param_universal_shift_reg.sv
// Bench for param_universal_shift_reg: 8- and 32-bit instances checked every cycle
// against a bit-level reference model, plus hand-computed literal expectations.
module tb_param_universal_shift_reg;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic [2:0]  mode = 3'b000;
    logic [2:0]  amt8 = 3'd0;
    logic [4:0]  amt32 = 5'd0;
    logic        msb_in = 1'b0;
    logic        lsb_in = 1'b0;
    logic [7:0]  in8 = 8'h00;
    logic [31:0] in32 = 32'h0;
    logic [7:0]  out8;
    logic [31:0] out32;
    logic        so8, so32, zero8, zero32;

    int tests = 0;
    int fails = 0;

    logic [7:0]  m8 = 8'h00;
    logic        s8 = 1'b0;
    logic [31:0] m32 = 32'h0;
    logic        s32 = 1'b0;

    always #5 clk = ~clk;

    param_universal_shift_reg #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .amt(amt8),
        .MSB_in(msb_in), .LSB_in(lsb_in), .in(in8),
        .out(out8), .shift_out(so8), .zero(zero8)
    );

    param_universal_shift_reg #(.WIDTH(32)) dut32 (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .amt(amt32),
        .MSB_in(msb_in), .LSB_in(lsb_in), .in(in32),
        .out(out32), .shift_out(so32), .zero(zero32)
    );

    function automatic logic is_shift(input logic [2:0] m);
        return (m == 3'd1) || (m == 3'd2) || (m == 3'd4) || (m == 3'd5) || (m == 3'd6);
    endfunction

    // Next register value built bit by bit from the mode definitions.
    function automatic logic [31:0] model_val(input int w, input logic [31:0] v, input logic [2:0] m,
                                              input int k, input logic msb, input logic lsb,
                                              input logic [31:0] d);
        logic [31:0] r;
        r = v;
        if (m == 3'd3) r = d;
        else if (m == 3'd7) r = 32'h0;
        else if (is_shift(m) && k != 0) begin
            for (int i = 0; i < w; i++) begin
                case (m)
                    3'd1:    r[i] = (i + k < w) ? v[i + k] : msb;
                    3'd2:    r[i] = (i >= k) ? v[i - k] : lsb;
                    3'd4:    r[i] = v[(i + k) % w];
                    3'd5:    r[i] = v[(i - k + w) % w];
                    default: r[i] = (i + k < w) ? v[i + k] : v[w - 1];
                endcase
            end
        end
        for (int i = w; i < 32; i++) r[i] = 1'b0;
        return r;
    endfunction

    function automatic logic model_so(input int w, input logic [31:0] v, input logic s,
                                      input logic [2:0] m, input int k);
        if (m == 3'd7) return 1'b0;
        if (!is_shift(m) || k == 0) return s;
        if (m == 3'd2 || m == 3'd5) return v[w - k];
        return v[k - 1];
    endfunction

    // Reference model state; reset clears it at once, otherwise advances on enabled edges.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m8 <= 8'h00; s8 <= 1'b0; m32 <= 32'h0; s32 <= 1'b0;
        end else if (en) begin
            m8  <= 8'(model_val(8, {24'h0, m8}, mode, int'(amt8), msb_in, lsb_in, {24'h0, in8}));
            s8  <= model_so(8, {24'h0, m8}, s8, mode, int'(amt8));
            m32 <= model_val(32, m32, mode, int'(amt32), msb_in, lsb_in, in32);
            s32 <= model_so(32, m32, s32, mode, int'(amt32));
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (fails <= 40)
                $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        chk("model_out8", {24'h0, out8}, {24'h0, m8});
        chk("model_so8", {31'h0, so8}, {31'h0, s8});
        chk("model_zero8", {31'h0, zero8}, {31'h0, (m8 == 8'h00)});
        chk("model_out32", out32, m32);
        chk("model_so32", {31'h0, so32}, {31'h0, s32});
        chk("model_zero32", {31'h0, zero32}, {31'h0, (m32 == 32'h0)});
    end

    // Apply one command just after a falling edge; returns at the next falling edge.
    task automatic op(input logic [2:0] m, input int k, input logic msb, input logic lsb,
                      input logic [31:0] d);
        #1;
        en = 1'b1; mode = m; amt8 = 3'(k); amt32 = 5'(k);
        msb_in = msb; lsb_in = lsb; in8 = d[7:0]; in32 = d;
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        chk("reset_out", {24'h0, out8}, 32'h0);
        chk("reset_zero", {31'h0, zero8}, 32'h1);
        #1 reset = 1'b0;
        @(negedge clk);

        // Asynchronous reset mid-cycle, then enable low ignores a load.
        op(3'd3, 0, 1'b0, 1'b0, 32'hA5);
        chk("load_a5", {24'h0, out8}, 32'hA5);
        #2 reset = 1'b1; en = 1'b0;
        #1;
        chk("async_out", {24'h0, out8}, 32'h0);
        chk("async_so", {31'h0, so8}, 32'h0);
        chk("async_zero", {31'h0, zero8}, 32'h1);
        #1 reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            #1 en = 1'b0; mode = 3'd3; in8 = 8'h3C; in32 = 32'h3C;
            @(negedge clk);
            chk("en_low_hold", {24'h0, out8}, 32'h0);
        end

        op(3'd3, 1, 1'b0, 1'b0, 32'hB4);
        op(3'd1, 1, 1'b1, 1'b0, 32'h0);
        chk("srl1_out", {24'h0, out8}, 32'hDA);
        chk("srl1_so", {31'h0, so8}, 32'h0);
        op(3'd2, 1, 1'b0, 1'b1, 32'h0);
        chk("sll1_out", {24'h0, out8}, 32'hB5);
        chk("sll1_so", {31'h0, so8}, 32'h1);
        op(3'd0, 1, 1'b0, 1'b0, 32'h0);
        chk("hold_out", {24'h0, out8}, 32'hB5);

        op(3'd3, 0, 1'b0, 1'b0, 32'h96);
        op(3'd1, 3, 1'b0, 1'b0, 32'h0);
        chk("srl3_out", {24'h0, out8}, 32'h12);
        chk("srl3_so", {31'h0, so8}, 32'h1);
        op(3'd3, 0, 1'b0, 1'b0, 32'h96);
        op(3'd2, 5, 1'b0, 1'b1, 32'h0);
        chk("sll5_out", {24'h0, out8}, 32'hDF);
        chk("sll5_so", {31'h0, so8}, 32'h0);

        op(3'd3, 0, 1'b0, 1'b0, 32'h81);
        op(3'd4, 1, 1'b0, 1'b0, 32'h0);
        chk("ror1_out", {24'h0, out8}, 32'hC0);
        chk("ror1_so", {31'h0, so8}, 32'h1);
        op(3'd5, 1, 1'b0, 1'b0, 32'h0);
        chk("rol1_out", {24'h0, out8}, 32'h81);
        chk("rol1_so", {31'h0, so8}, 32'h1);
        op(3'd3, 0, 1'b0, 1'b0, 32'h0F);
        op(3'd5, 4, 1'b0, 1'b0, 32'h0);
        chk("rol4_out", {24'h0, out8}, 32'hF0);

        op(3'd3, 0, 1'b0, 1'b0, 32'h80);
        op(3'd6, 7, 1'b0, 1'b0, 32'h0);
        chk("asr7_out", {24'h0, out8}, 32'hFF);
        chk("asr7_so", {31'h0, so8}, 32'h0);
        op(3'd3, 0, 1'b0, 1'b0, 32'h7E);
        op(3'd6, 2, 1'b0, 1'b0, 32'h0);
        chk("asr2_out", {24'h0, out8}, 32'h1F);
        chk("asr2_so", {31'h0, so8}, 32'h1);
        op(3'd7, 3, 1'b1, 1'b1, 32'hFF);
        chk("clear_out", {24'h0, out8}, 32'h0);
        chk("clear_so", {31'h0, so8}, 32'h0);
        chk("clear_zero", {31'h0, zero8}, 32'h1);

        op(3'd3, 0, 1'b0, 1'b0, 32'hDEAD_BEEF);
        op(3'd1, 4, 1'b0, 1'b0, 32'h0);
        chk("w32_srl4_out", out32, 32'h0DEA_DBEE);
        chk("w32_srl4_so", {31'h0, so32}, 32'h1);
        op(3'd1, 0, 1'b1, 1'b1, 32'h0);
        chk("w32_srl0_out", out32, 32'h0DEA_DBEE);
        chk("w32_srl0_so", {31'h0, so32}, 32'h1);
        op(3'd3, 0, 1'b0, 1'b0, 32'h8000_0001);
        op(3'd4, 31, 1'b0, 1'b0, 32'h0);
        chk("w32_ror31_out", out32, 32'h0000_0003);
        chk("w32_ror31_so", {31'h0, so32}, 32'h0);

        // Randomised traffic, including occasional reset pulses and enable drops.
        for (int c = 0; c < 10000; c++) begin
            #1;
            reset  = ($urandom_range(0, 399) == 0);
            en     = ($urandom_range(0, 7) != 0);
            mode   = 3'($urandom_range(0, 7));
            amt8   = 3'($urandom_range(0, 7));
            amt32  = 5'($urandom_range(0, 31));
            msb_in = 1'($urandom_range(0, 1));
            lsb_in = 1'($urandom_range(0, 1));
            in8    = 8'($urandom);
            in32   = $urandom;
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/param_universal_shift_reg.md
Name: param_universal_shift_reg

Overview:
- Parametrised universal shift register. It is the next-generation register for the datapath library.
- Adds generic WIDTH, multi-position shifts per cycle, rotate and arithmetic-shift modes, a clock enable, a shifted-out bit flag and a zero flag.
- Mode encodings 000–011 keep the original hold / shift-right / shift-left / load semantics, so existing users of the 8-bit register can migrate without changes.
- Sits in datapath and serialiser paths wherever a multi-mode register stage is needed.

Parameters:
- WIDTH, 8, register width in bits; must be ≥2 and a power of two.
- AW, $clog2(WIDTH), width of the shift-amount port; derived, must not be overridden.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; clears all state immediately
- en  input  1  clock enable; 0 = hold all state regardless of mode
- mode  input  3  operation select (encodings in Behaviour)
- amt  input  AW  shift/rotate distance k, range 0..WIDTH-1; ignored by hold/load/clear
- MSB_in  input  1  serial fill bit for logical shift right
- LSB_in  input  1  serial fill bit for shift left
- in  input  WIDTH  parallel load data
- out  output  WIDTH  register contents
- shift_out  output  1  registered copy of the last bit shifted or rotated out
- zero  output  1  combinational, high when out == 0

Behaviour:
- Reset
  - reset=1 forces out=0 and shift_out=0 asynchronously, independent of clk.
  - zero therefore reads 1 during reset.
  - Reset asserted mid-operation aborts that operation; no partial update survives.
  - First update occurs on the first rising clk edge after reset deasserts.
- Update timing
  - All updates happen on the rising clk edge when reset=0 and en=1.
  - Latency is one cycle: a result is visible on out the cycle after the command is sampled.
  - en=0: out and shift_out hold; mode, amt and data inputs are don't-care.
- Modes (W=WIDTH, k=amt):
  - 000 HOLD: out and shift_out unchanged.
  - 001 SRL: out={k copies of MSB_in, out[W-1:k]}; shift_out=out[k-1].
  - 010 SLL: out={out[W-1-k:0], k copies of LSB_in}; shift_out=out[W-k].
  - 011 LOAD: out=in; shift_out unchanged.
  - 100 ROR: out={out[k-1:0], out[W-1:k]}; shift_out=out[k-1].
  - 101 ROL: out={out[W-1-k:0], out[W-1:W-k]}; shift_out=out[W-k].
  - 110 ASR: out={k copies of out[W-1], out[W-1:k]}; shift_out=out[k-1].
  - 111 CLEAR: out=0; shift_out=0.
- All right-hand sides use the pre-edge value of out.
- k=0 in any shift or rotate mode: out and shift_out both unchanged (behaves as HOLD).
- k is unsigned; the maximum distance is W-1. Shifting by W is not expressible and needs two operations.
- ASR preserves the sign bit for every k, e.g. 8'h80 ASR 7 = 8'hFF.
- Rotates never lose data: ROR by k followed by ROL by k restores the original value.
- No X propagation: every mode fully defines out. Only 111 clears, so no default case is reachable.
- zero is purely combinational from out, with no extra latency.

Test Plan:
1. Reset/enable: assert reset mid-cycle with out=8'hA5 → out=8'h00, shift_out=0, zero=1 before the next clk edge. With en=0, mode=011, in=8'h3C for 3 cycles → out stays 8'h00.
2. Legacy modes, amt=1, WIDTH=8:
   - load 8'hB4;
   - SRL with MSB_in=1 → out=8'hDA, shift_out=0;
   - SLL with LSB_in=1 → out=8'hB5, shift_out=1;
   - HOLD → unchanged.
3. Multi-bit shifts: load 8'h96, SRL k=3 with MSB_in=0 → out=8'h12, shift_out=1. Load 8'h96, SLL k=5 with LSB_in=1 → out=8'hDF, shift_out=0.
4. Rotates: load 8'h81, ROR k=1 → 8'hC0, shift_out=1. Then ROL k=1 → 8'h81, shift_out=1. Load 8'h0F, ROL k=4 → 8'hF0.
5. ASR and clear: load 8'h80, ASR k=7 → 8'hFF, shift_out=0. Load 8'h7E, ASR k=2 → 8'h1F, shift_out=1. CLEAR → out=0, shift_out=0, zero=1.
6. Edge cases with WIDTH=32 (AW=5): SRL k=0 → out and shift_out unchanged. Load 32'h8000_0001, ROR k=31 → 32'h0000_0003, shift_out=0. Randomised modes and amt checked against a reference model over 10k cycles.
